// File: rtl/dig_fe_ro_pkg.sv
// Shared types and helpers for the digital front-end readout sequencer.
// Holds the sequencer state encoding, bank identifiers and index-width sizing.
package dig_fe_ro_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ro_state_e;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // Index width that never collapses to zero for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dig_fe_word_buf.sv
// One-row holding buffer: parallel-loads COL pixel words and emits them
// column by column over a valid/ready handshake.
module dig_fe_word_buf
    import dig_fe_ro_pkg::*;
#(
    parameter int COL   = 2,
    parameter int CNT_W = 12,
    parameter int ROW_W = 1,
    parameter int COL_W = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [COL*CNT_W-1:0] words_i,
    input  logic [ROW_W-1:0]     row_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [CNT_W-1:0]     data_o,
    output logic [ROW_W-1:0]     row_o,
    output logic [COL_W-1:0]     col_o,
    output logic                 empty_o,
    output logic                 free_o
);

    logic [COL*CNT_W-1:0] words_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic                 valid_q;
    logic                 hs_s;
    logic                 last_s;

    assign hs_s   = valid_q & ready_i;
    assign last_s = (col_q == COL_W'(COL - 1));
    // Free also when the final column leaves this cycle, so a new row can land back-to-back.
    assign free_o = ~valid_q | (hs_s & last_s);

    // Buffer contents, output column pointer and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            words_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            words_q <= words_i;
            row_q   <= row_i;
            col_q   <= '0;
            valid_q <= 1'b1;
        end else if (hs_s) begin
            if (last_s) begin
                col_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                col_q   <= col_q + COL_W'(1);
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = words_q[col_q*CNT_W +: CNT_W];
    assign row_o   = row_q;
    assign col_o   = col_q;
    assign empty_o = ~valid_q;

endmodule

// File: rtl/dig_fe_readout_ctrl.sv
// Readout sequencer for the Row x Col pixel array: drives load/shift strobes and
// A/B shutters, deserialises the column chains and streams pixel words out.
module dig_fe_readout_ctrl
    import dig_fe_ro_pkg::*;
#(
    parameter int ROW   = 2,
    parameter int COL   = 2,
    parameter int CNT_W = 12
) (
    input  logic                    readClk,
    input  logic                    reset,
    input  logic                    frameStart,
    input  logic                    contMode,
    input  logic                    shutterReq,
    input  logic [COL-1:0]          serInA,
    input  logic [COL-1:0]          serInB,
    output logic                    shutterA,
    output logic                    shutterB,
    output logic                    serLoad,
    output logic                    serShift,
    output logic                    bankSel,
    output logic [CNT_W-1:0]        pixData,
    output logic [idx_w(ROW)-1:0]   pixRow,
    output logic [idx_w(COL)-1:0]   pixCol,
    output logic                    pixValid,
    input  logic                    pixReady,
    output logic                    busy,
    output logic                    frameDone,
    output logic                    overrun
);

    localparam int RW = idx_w(ROW);
    localparam int CW = idx_w(COL);
    localparam int BW = idx_w(CNT_W);

    ro_state_e            state_q, state_d;
    logic                 active_bank_q, active_bank_d;
    logic                 bank_sel_q, bank_sel_d;
    logic                 cont_q;
    logic                 shutter_a_q, shutter_b_q;
    logic                 overrun_q;
    logic [BW-1:0]        bit_q, bit_d;
    logic [RW-1:0]        row_q, row_d;
    logic [COL*CNT_W-1:0] deser_q, deser_d;

    logic                 busy_s, mode_s, last_bit_s, last_row_s;
    logic                 shift_s, buf_load_s, buf_free_s, buf_empty_s;
    logic [COL-1:0]       ser_s;

    assign busy_s     = (state_q != IDLE);
    // Mode is only taken from the pin while idle; a running frame keeps its own.
    assign mode_s     = (state_q == IDLE) ? contMode : cont_q;
    assign ser_s      = (bank_sel_q == BANK_B) ? serInB : serInA;
    assign last_bit_s = (bit_q == BW'(CNT_W - 1));
    assign last_row_s = (row_q == RW'(ROW - 1));

    // Deserialiser next value: every column shifts in its bit, MSB first.
    always_comb begin
        deser_d = deser_q;
        for (int c = 0; c < COL; c++) begin
            deser_d[c*CNT_W +: CNT_W] = {deser_q[c*CNT_W +: CNT_W-1], ser_s[c]};
        end
    end

    // Sequencer next-state, bank selection and shift/stall decisions.
    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        bank_sel_d    = bank_sel_q;
        bit_d         = bit_q;
        row_d         = row_q;
        shift_s       = 1'b0;
        buf_load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frameStart) begin
                    state_d = LOAD;
                    if (contMode) begin
                        bank_sel_d    = active_bank_q;
                        active_bank_d = ~active_bank_q;
                    end else begin
                        bank_sel_d    = BANK_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                bit_d   = '0;
                row_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Hold the final bit of a row until the buffer can take the whole row.
                shift_s = ~last_bit_s | buf_free_s;
                if (shift_s && last_bit_s) begin
                    buf_load_s = 1'b1;
                    bit_d      = '0;
                    if (last_row_s) begin
                        state_d = DRAIN;
                    end else begin
                        row_d   = row_q + RW'(1);
                    end
                end else if (shift_s) begin
                    bit_d = bit_q + BW'(1);
                end else begin
                    bit_d = bit_q;
                end
            end
            DRAIN: begin
                if (buf_empty_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, deserialisers, shutters and sticky overrun flag.
    always_ff @(posedge readClk) begin
        if (!reset) begin
            state_q       <= IDLE;
            active_bank_q <= BANK_A;
            bank_sel_q    <= BANK_A;
            cont_q        <= 1'b0;
            shutter_a_q   <= 1'b0;
            shutter_b_q   <= 1'b0;
            overrun_q     <= 1'b0;
            bit_q         <= '0;
            row_q         <= '0;
            deser_q       <= '0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            bank_sel_q    <= bank_sel_d;
            cont_q        <= mode_s;
            bit_q         <= bit_d;
            row_q         <= row_d;
            if (shift_s) begin
                deser_q <= deser_d;
            end
            if (frameStart && busy_s) begin
                overrun_q <= 1'b1;
            end
            if (mode_s) begin
                shutter_a_q <= shutterReq & (active_bank_q == BANK_A);
                shutter_b_q <= shutterReq & (active_bank_q == BANK_B);
            end else begin
                shutter_a_q <= shutterReq & ~busy_s;
                shutter_b_q <= shutterReq & ~busy_s;
            end
        end
    end

    dig_fe_word_buf #(
        .COL   (COL),
        .CNT_W (CNT_W),
        .ROW_W (RW),
        .COL_W (CW)
    ) u_word_buf (
        .clk_i   (readClk),
        .rst_ni  (reset),
        .load_i  (buf_load_s),
        .words_i (deser_d),
        .row_i   (row_q),
        .ready_i (pixReady),
        .valid_o (pixValid),
        .data_o  (pixData),
        .row_o   (pixRow),
        .col_o   (pixCol),
        .empty_o (buf_empty_s),
        .free_o  (buf_free_s)
    );

    assign shutterA  = shutter_a_q;
    assign shutterB  = shutter_b_q;
    assign serLoad   = (state_q == LOAD);
    assign serShift  = shift_s;
    assign bankSel   = bank_sel_q;
    assign busy      = busy_s;
    assign frameDone = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dig_fe_readout_ctrl.sv
// Self-checking bench for dig_fe_readout_ctrl: models the column chains and
// checks streamed words against a row/col-ordered scoreboard.
module tb_dig_fe_readout_ctrl;
    import dig_fe_ro_pkg::*;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int W  = 4;
    localparam int NB = R * W;
    localparam int RW = 1;
    localparam int CW = 1;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic [W-1:0]  d;
    } word_t;

    logic          readClk = 1'b0;
    logic          reset, frameStart, contMode, shutterReq, pixReady;
    logic [C-1:0]  serInA, serInB;
    logic          shutterA, shutterB, serLoad, serShift, bankSel;
    logic [W-1:0]  pixData;
    logic [RW-1:0] pixRow;
    logic [CW-1:0] pixCol;
    logic          pixValid, busy, frameDone, overrun;

    always #5 readClk = ~readClk;

    dig_fe_readout_ctrl #(.ROW(R), .COL(C), .CNT_W(W)) dut (
        .readClk    (readClk),
        .reset      (reset),
        .frameStart (frameStart),
        .contMode   (contMode),
        .shutterReq (shutterReq),
        .serInA     (serInA),
        .serInB     (serInB),
        .shutterA   (shutterA),
        .shutterB   (shutterB),
        .serLoad    (serLoad),
        .serShift   (serShift),
        .bankSel    (bankSel),
        .pixData    (pixData),
        .pixRow     (pixRow),
        .pixCol     (pixCol),
        .pixValid   (pixValid),
        .pixReady   (pixReady),
        .busy       (busy),
        .frameDone  (frameDone),
        .overrun    (overrun)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    word_t       exp_q[$];
    logic [NB-1:0] ch_a[C];
    logic [NB-1:0] ch_b[C];
    logic [W-1:0]  fdat[R][C];
    logic        act_bank_m, exp_bank, bank_at_load, sh_a_mid, sh_b_mid;
    bit          sb_en;
    int          start_cyc, load_cyc, n_load, n_shift, n_done;
    int          first_valid_cyc, last_shift_cyc, done_cyc, last_hs_cyc;
    int          rdy_mode, rdy_lo, rdy_hi;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance the chain model.
    task automatic tick();
        logic          ld, sh;
        word_t         w;
        logic [NB-1:0] bits;
        @(negedge readClk);
        ld = serLoad;
        sh = serShift;
        if (sb_en) begin
            if (ld) begin
                n_load++;
                load_cyc     = cyc;
                bank_at_load = bankSel;
            end
            if (sh) begin
                n_shift++;
                last_shift_cyc = cyc;
            end
            if (frameDone) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cyc == start_cyc + 3) begin
                sh_a_mid = shutterA;
                sh_b_mid = shutterB;
            end
            if (pixValid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", 32'(pixValid), 32'd0);
                end else begin
                    w = exp_q[0];
                    check_eq("pix_row", 32'(pixRow), 32'(w.r));
                    check_eq("pix_col", 32'(pixCol), 32'(w.c));
                    check_eq("pix_data", 32'(pixData), 32'(w.d));
                    if (pixReady) begin
                        void'(exp_q.pop_front());
                        last_hs_cyc = cyc;
                    end
                end
            end
        end
        @(posedge readClk);
        #1;
        cyc++;
        for (int c = 0; c < C; c++) begin
            if (ld) begin
                for (int r = 0; r < R; r++) bits[NB-1-r*W -: W] = fdat[r][c];
                ch_a[c] = (exp_bank == BANK_A) ? bits : NB'($urandom);
                ch_b[c] = (exp_bank == BANK_B) ? bits : NB'($urandom);
            end else if (sh) begin
                ch_a[c] = ch_a[c] << 1;
                ch_b[c] = ch_b[c] << 1;
            end
            serInA[c] = ch_a[c][NB-1];
            serInB[c] = ch_b[c][NB-1];
        end
        case (rdy_mode)
            1: begin
                pixReady = ($urandom_range(0, 9) < 6);
                contMode = 1'($urandom);
            end
            2: pixReady = !(cyc >= start_cyc + rdy_lo && cyc <= start_cyc + rdy_hi);
            default: pixReady = 1'b1;
        endcase
    endtask

    // Runs one frame from IDLE; dup_at > 0 re-asserts frameStart that many cycles in.
    task automatic run_frame(input logic cont, input int dup_at);
        word_t w;
        int    budget;
        first_valid_cyc = -1;
        last_shift_cyc  = -1;
        done_cyc        = -1;
        last_hs_cyc     = -1;
        load_cyc        = -1;
        n_load  = 0;
        n_shift = 0;
        n_done  = 0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                w.r = RW'(r);
                w.c = CW'(c);
                w.d = fdat[r][c];
                exp_q.push_back(w);
            end
        end
        if (cont) begin
            exp_bank   = act_bank_m;
            act_bank_m = ~act_bank_m;
        end else begin
            exp_bank   = BANK_A;
        end
        contMode   = cont;
        start_cyc  = cyc;
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        budget = 0;
        while (n_done == 0 && budget < 600) begin
            frameStart = (dup_at > 0 && cyc == start_cyc + dup_at);
            tick();
            budget++;
        end
        frameStart = 1'b0;
        check_eq("frame_done_seen", 32'(n_done > 0), 32'd1);
        repeat (3) tick();
        check_eq("frame_done_once", n_done, 32'd1);
        check_eq("load_count", n_load, 32'd1);
        check_eq("shift_count", n_shift, NB);
        check_eq("words_left", exp_q.size(), 32'd0);
        check_eq("bank_sel", 32'(bank_at_load), 32'(exp_bank));
        check_eq("done_after_last_word", 32'(done_cyc > last_hs_cyc), 32'd1);
        check_eq("idle_after_frame", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero();
        check_eq("rst_ctrl_outs",
                 32'({shutterA, shutterB, serLoad, serShift, bankSel, pixValid, busy, frameDone, overrun}),
                 32'd0);
        check_eq("rst_pix_data", 32'(pixData), 32'd0);
        check_eq("rst_pix_idx", 32'({pixRow, pixCol}), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        frameStart = 1'b0;
        contMode   = 1'b0;
        shutterReq = 1'b0;
        pixReady   = 1'b1;
        serInA     = '0;
        serInB     = '0;
        for (int c = 0; c < C; c++) begin
            ch_a[c] = '0;
            ch_b[c] = '0;
        end
        sb_en      = 1'b0;
        act_bank_m = BANK_A;
        exp_bank   = BANK_A;
        start_cyc  = -100;
        rdy_mode   = 0;
        rdy_lo     = 0;
        rdy_hi     = 0;

        repeat (3) tick();
        reset = 1'b1;
        check_all_zero();
        sb_en = 1'b1;

        // Sequential frame with idle/busy shutter gating.
        shutterReq = 1'b1;
        repeat (2) tick();
        check_eq("seq_idle_shutter", 32'({shutterA, shutterB}), 32'b11);
        fdat[0][0] = 4'hA; fdat[1][0] = 4'h3;
        fdat[0][1] = 4'h5; fdat[1][1] = 4'hF;
        run_frame(1'b0, 0);
        check_eq("seq_load_cycle", load_cyc - start_cyc, 32'd1);
        check_eq("seq_first_valid", first_valid_cyc - start_cyc, 32'd6);
        check_eq("seq_last_shift", last_shift_cyc - start_cyc, 32'd9);
        check_eq("seq_busy_shutter", 32'({sh_a_mid, sh_b_mid}), 32'b00);

        // Backpressure: sink stalls t+5..t+20, last row-1 bit waits for the buffer.
        rdy_mode = 2;
        rdy_lo   = 5;
        rdy_hi   = 20;
        run_frame(1'b0, 0);
        rdy_mode = 0;
        check_eq("bp_first_valid", first_valid_cyc - start_cyc, 32'd6);
        check_eq("bp_last_shift", last_shift_cyc - start_cyc, 32'd22);

        // Continuous mode: bank A read while B counts, then the reverse.
        fdat[0][0] = 4'h1; fdat[1][0] = 4'hE;
        fdat[0][1] = 4'h7; fdat[1][1] = 4'h8;
        run_frame(1'b1, 0);
        check_eq("cont1_shutters", 32'({sh_a_mid, sh_b_mid}), 32'b01);
        fdat[0][0] = 4'hC; fdat[1][0] = 4'h6;
        fdat[0][1] = 4'h2; fdat[1][1] = 4'h9;
        run_frame(1'b1, 0);
        check_eq("cont2_shutters", 32'({sh_a_mid, sh_b_mid}), 32'b10);

        // Overrun: a second frameStart mid-frame is ignored but flagged.
        check_eq("overrun_clear", 32'(overrun), 32'd0);
        run_frame(1'b0, 3);
        check_eq("overrun_set", 32'(overrun), 32'd1);

        // Randomised frames, modes, shutter request and sink readiness.
        rdy_mode = 1;
        for (int f = 0; f < 24; f++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) fdat[r][c] = W'($urandom);
            shutterReq = 1'($urandom);
            run_frame(1'($urandom), 0);
        end
        rdy_mode = 0;
        check_eq("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of shifting discards the frame.
        exp_bank   = BANK_A;
        contMode   = 1'b0;
        start_cyc  = cyc;
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        repeat (4) tick();
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        sb_en = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        act_bank_m = BANK_A;
        check_all_zero();
        sb_en = 1'b1;
        repeat (20) tick();
        check_eq("post_reset_idle", 32'({busy, pixValid, overrun}), 32'd0);

        // Recovery frame after reset.
        fdat[0][0] = 4'h4; fdat[1][0] = 4'hB;
        fdat[0][1] = 4'hD; fdat[1][1] = 4'h0;
        run_frame(1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
